pipa_moding_gen: RTL

Synthesizable PIPA (pulsed integrating pendulous accelerometer) emulator for the AGC simulation environment. It consumes the AGC outputs PIPASW (moding switch) and PIPDAT (data strobe) and drives the six PIPA inputs PIPAXp/PIPAXm/PIPAYp/PIPAYm/PIPAZp/PIPAZm. The moding is per-axis programmable, so a bench or FPGA top level can apply a constant net acceleration instead of zero-net 3-3 moding. Per-axis signed net-pulse counters let a checker compare the AGC PIPA counters against the injected delta-V.

---
 rtl/pipa_moding_gen.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pipa_moding_gen.sv
// rtl/pipa_moding_gen.sv - PIPA moding emulator driven by AGC PIPASW/PIPDAT strobes
module pipa_moding_gen #(
   parameter int FRAME_LEN    = 6,
   parameter int DEFAULT_PLUS = 3,
   parameter int CNT_W        = 16
) (
   input  logic             SIM_CLK,
   input  logic             SIM_RST_n,
   input  logic             PIPASW,
   input  logic             PIPDAT,
   input  logic             EN,
   input  logic [2:0]       CFG_X,
   input  logic [2:0]       CFG_Y,
   input  logic [2:0]       CFG_Z,
   output logic             PIPAXp,
   output logic             PIPAXm,
   output logic             PIPAYp,
   output logic             PIPAYm,
   output logic             PIPAZp,
   output logic             PIPAZm,
   output logic [2:0]       PHASE,
   output logic             FRAME,
   output logic [CNT_W-1:0] NETX,
   output logic [CNT_W-1:0] NETY,
   output logic [CNT_W-1:0] NETZ
);

   localparam logic [2:0]       LP_LAST = 3'(FRAME_LEN - 1);
   localparam logic [2:0]       LP_LEN  = 3'(FRAME_LEN);
   localparam logic [2:0]       LP_DEF  = 3'(DEFAULT_PLUS);
   localparam logic [CNT_W-1:0] LP_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   // synchronizers and edge history
   logic             r_sw_s1;
   logic             r_sw_s2;
   logic             r_sw_prev;
   logic [1:0]       r_arm;
   logic             r_dat_s1;
   logic             r_dat_s2;

   // moding state
   logic [2:0]       r_phase;
   logic             r_frame;
   logic [2:0]       r_k [3];

   // registered outputs, their one-cycle history, and net counters
   logic [2:0]       r_plus;
   logic [2:0]       r_minus;
   logic [2:0]       r_plus_d;
   logic [2:0]       r_minus_d;
   logic [CNT_W-1:0] r_net [3];

   // combinational helpers
   logic             w_sw_rise;
   logic             w_adv;
   logic             w_wrap;
   logic [2:0]       w_ph_next;
   logic [2:0]       w_cfg [3];
   logic [2:0]       w_cfg_cl [3];
   logic [2:0]       w_k_eff [3];
   logic [2:0]       w_sel_plus;
   logic             w_dat_on;

   assign w_cfg[0] = CFG_X;
   assign w_cfg[1] = CFG_Y;
   assign w_cfg[2] = CFG_Z;

   // Two-flop synchronizers. r_arm keeps r_sw_prev high until the chain holds
   // only post-reset samples, so a PIPASW that is already high at reset
   // release never looks like a fresh rise.
   always_ff @(posedge SIM_CLK) begin
      if (!SIM_RST_n) begin
         r_sw_s1   <= 1'b0;
         r_sw_s2   <= 1'b0;
         r_sw_prev <= 1'b1;
         r_arm     <= 2'b00;
         r_dat_s1  <= 1'b0;
         r_dat_s2  <= 1'b0;
      end else begin
         r_sw_s1   <= PIPASW;
         r_sw_s2   <= r_sw_s1;
         r_arm     <= {r_arm[0], 1'b1};
         r_sw_prev <= r_arm[1] ? r_sw_s2 : 1'b1;
         r_dat_s1  <= PIPDAT;
         r_dat_s2  <= r_dat_s1;
      end
   end

   // Phase advance decode, next phase, and the k values in force for ph_next
   always_comb begin
      w_sw_rise = r_sw_s2 & ~r_sw_prev;
      w_adv     = EN & w_sw_rise;
      w_wrap    = w_adv & (r_phase == LP_LAST);
      w_ph_next = r_phase;
      if (w_adv) begin
         w_ph_next = w_wrap ? 3'd0 : r_phase + 3'd1;
      end
      w_dat_on  = EN & r_dat_s2;
      for (int a = 0; a < 3; a++) begin
         w_cfg_cl[a]   = (w_cfg[a] > LP_LEN) ? LP_LEN : w_cfg[a];
         // At a wrap the freshly loaded k already governs phase 0.
         w_k_eff[a]    = w_wrap ? w_cfg_cl[a] : r_k[a];
         w_sel_plus[a] = (w_ph_next < w_k_eff[a]);
      end
   end

   // Phase counter, frame pulse and active-config load at the wrap
   always_ff @(posedge SIM_CLK) begin
      if (!SIM_RST_n) begin
         r_phase <= 3'd0;
         r_frame <= 1'b0;
         for (int a = 0; a < 3; a++) begin
            r_k[a] <= LP_DEF;
         end
      end else begin
         r_phase <= w_ph_next;
         r_frame <= w_wrap;
         if (w_wrap) begin
            for (int a = 0; a < 3; a++) begin
               r_k[a] <= w_cfg_cl[a];
            end
         end
      end
   end

   // Output register: selection uses ph_next so a coincident PIPASW rise
   // never leaves an old-phase sliver on the opposite-sign line.
   always_ff @(posedge SIM_CLK) begin
      if (!SIM_RST_n) begin
         r_plus  <= 3'b000;
         r_minus <= 3'b000;
      end else begin
         r_plus  <= {3{w_dat_on}} &  w_sel_plus;
         r_minus <= {3{w_dat_on}} & ~w_sel_plus;
      end
   end

   // Net counters step on each rising edge of the registered outputs
   always_ff @(posedge SIM_CLK) begin
      if (!SIM_RST_n) begin
         r_plus_d  <= 3'b000;
         r_minus_d <= 3'b000;
         for (int a = 0; a < 3; a++) begin
            r_net[a] <= '0;
         end
      end else begin
         r_plus_d  <= r_plus;
         r_minus_d <= r_minus;
         for (int a = 0; a < 3; a++) begin
            if (r_plus[a] & ~r_plus_d[a]) begin
               r_net[a] <= r_net[a] + LP_ONE;
            end else if (r_minus[a] & ~r_minus_d[a]) begin
               r_net[a] <= r_net[a] - LP_ONE;
            end
         end
      end
   end

   assign PIPAXp = r_plus[0];
   assign PIPAXm = r_minus[0];
   assign PIPAYp = r_plus[1];
   assign PIPAYm = r_minus[1];
   assign PIPAZp = r_plus[2];
   assign PIPAZm = r_minus[2];
   assign PHASE  = r_phase;
   assign FRAME  = r_frame;
   assign NETX   = r_net[0];
   assign NETY   = r_net[1];
   assign NETZ   = r_net[2];

endmodule
